vote_tally_ctrl: RTL
====================

Name: vote_tally_ctrl

Overview:
Parametrised ballot counter for the EVM datapath. Accepts one vote per button press from NUM_CAND candidate inputs and rejects multi-button presses. Counters saturate instead of wrapping. A post-press lockout blocks bounce. On entry to result mode, a sequential scan finds the leader and flags ties. Sits between the button-sync stage and the display/result mux.

Parameters:
NUM_CAND, 6, number of candidate inputs (2..32)
COUNT_W, 8, width of each per-candidate counter
LOCKOUT, 4, cycles after an accepted vote before release detection resumes (>=1)
IDX_W, $clog2(NUM_CAND), width of winner index (derived localparam)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mode  in  1  0 = voting, 1 = result
clear  in  1  synchronous clear of all tallies, active-high
cand_press  in  NUM_CAND  synchronised level inputs, bit i = candidate i button held
counts  out  NUM_CAND*COUNT_W  flattened tallies, candidate i at [i*COUNT_W +: COUNT_W]
total  out  COUNT_W+IDX_W+1  sum of accepted votes
vote_accept  out  1  one-cycle pulse when a vote is counted
vote_reject  out  1  one-cycle pulse on multi-press or a press while saturated
winner_idx  out  IDX_W  index of the leading candidate
winner_valid  out  1  scan complete, winner_idx/tie stable
tie  out  1  max tally shared by more than one candidate
busy  out  1  scan in progress

Behaviour:
- Reset (reset_n low, async): all counts=0, total=0, pulses=0, winner_idx=0, winner_valid=0, tie=0, busy=0, FSM=IDLE.
- Press FSM states and transitions:
  - IDLE: wait until cand_press==0, then go to ARMED.
  - ARMED: act only when mode==0 and cand_press!=0.
  - ARMED, exactly one bit set: count, go to LOCK.
  - ARMED, more than one bit set: vote_reject, go to IDLE.
  - LOCK: count LOCKOUT cycles, then go to IDLE. Presses are ignored throughout LOCK.
- A held button is counted once; counting again requires a full release.
- Accept (ARMED, onehot, mode==0, target count < 2^COUNT_W-1):
  - Tally and total increment on the same edge.
  - vote_accept is high the cycle after the edge on which the press was sampled. Latency 1.
- Saturated target: no increment, vote_reject pulses, FSM goes to LOCK.
- mode==1: cand_press is ignored and the FSM is forced to IDLE. A press still held when mode returns to 0 is not counted until it is released.
- Result scan:
  - Starts on the mode 0->1 edge. busy=1 and winner_valid=0 for NUM_CAND cycles, one index per cycle.
  - Strict greater-than compare: lowest index wins among equals.
  - tie=1 if any later index equals the running max.
  - On the cycle after the last index: winner_valid=1, busy=0.
  - All counts zero: winner_idx=0, tie=1 (NUM_CAND>=2).
- mode 1->0: winner_valid and tie clear on the next edge. A scan aborted this way leaves winner_valid=0.
- clear:
  - Zeroes counts and total, and clears winner_valid and tie.
  - Aborts any scan. It does not restart; a new scan needs a new 0->1 edge.
  - clear and accept on the same edge: clear wins, no pulse.
- Mid-lockout reset: async return to the reset state, no partial count.
- Width rule: total never overflows, because its width is sized for NUM_CAND saturated counters.

Decomposition:
- Shared package evm_pkg holds:
  - press FSM state encoding (IDLE, ARMED, LOCK);
  - scan state encoding (SCAN_IDLE, SCAN_RUN, SCAN_DONE);
  - onehot-check function;
  - saturation max constant function of COUNT_W.
- One sub-module, vote_press_filter.
  - Contains: press FSM, lockout counter, onehot/multi-press detection.
  - Outputs: a registered valid pulse and an index to the tally logic.
- Tally array and scan stay in vote_tally_ctrl.

Test Plan:
1. Reset, mode=0, press cand 2 for 10 cycles then release, repeat 3x -> counts[2]=3, total=3, three vote_accept pulses, all other counts 0.
2. Press bits 1 and 4 together -> vote_reject one cycle, no count change. Release, then press bit 4 -> counts[4]=1.
3. COUNT_W=4, press cand 0 17 times -> counts[0]=15, total=15, 15 accepts, 2 rejects.
4. Tallies {3,5,5,1,0,2}, raise mode -> busy for 6 cycles, then winner_idx=1, tie=1, winner_valid=1. Drop mode -> winner_valid=0 next edge.
5. Press on LOCK cycle 2 with LOCKOUT=4 and release -> not counted. Assert clear with a valid press -> counts all 0, no accept.
6. reset_n low mid-scan and mid-LOCK -> all outputs 0 immediately. After release, press cand 5 -> counts[5]=1.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and helpers for the EVM ballot datapath: press/scan state
// encodings, one-hot detection and the saturation ceiling of a tally.
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOCK  = 2'd2
  } press_state_e;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_RUN  = 2'd1,
    SCAN_DONE = 2'd2
  } scan_state_e;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/vote_press_filter.sv
// Button press qualifier: counts a held button once, rejects multi-presses,
// and holds off for LOCKOUT cycles after every single-button decision.
module vote_press_filter
  import evm_pkg::*;
#(
  parameter int NUM_CAND = 6,
  parameter int LOCKOUT  = 4,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                mode_i,
  input  logic                clear_i,
  input  logic [NUM_CAND-1:0] press_i,
  input  logic [NUM_CAND-1:0] sat_i,
  output logic                valid_o,
  output logic                reject_o,
  output logic [IDX_W-1:0]    idx_o
);

  localparam int LOCK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT - 1);

  press_state_e      state_q, state_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              valid_q, valid_d;
  logic              reject_q, reject_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  enc_s;
  logic              onehot_s;

  // Encode the pressed index; only used when exactly one bit is set.
  always_comb begin
    enc_s = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      enc_s = press_i[i] ? IDX_W'(i) : enc_s;
    end
  end

  assign onehot_s = is_onehot(32'(press_i));

  // Press FSM next state; result mode and clear both force a fresh release.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    valid_d  = 1'b0;
    reject_d = 1'b0;
    idx_d    = idx_q;
    if (mode_i || clear_i) begin
      state_d = IDLE;
      lock_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = (press_i == '0) ? ARMED : IDLE;
        end
        ARMED: begin
          if (press_i == '0) begin
            state_d = ARMED;
          end else if (onehot_s) begin
            idx_d    = enc_s;
            valid_d  = ~sat_i[enc_s];
            reject_d = sat_i[enc_s];
            state_d  = LOCK;
            lock_d   = '0;
          end else begin
            reject_d = 1'b1;
            state_d  = IDLE;
          end
        end
        LOCK: begin
          if (lock_q == LOCK_LAST) begin
            state_d = IDLE;
            lock_d  = '0;
          end else begin
            lock_d = lock_q + LOCK_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          lock_d  = '0;
        end
      endcase
    end
  end

  // State and registered decision pulses.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      lock_q   <= '0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
      idx_q    <= idx_d;
    end
  end

  assign valid_o  = valid_q;
  assign reject_o = reject_q;
  assign idx_o    = idx_q;

endmodule

// File: rtl/vote_tally_ctrl.sv
// Ballot counter: saturating per-candidate tallies fed by the press filter,
// plus a one-index-per-cycle leader scan launched on entry to result mode.
module vote_tally_ctrl
  import evm_pkg::*;
#(
  parameter  int NUM_CAND = 6,
  parameter  int COUNT_W  = 8,
  parameter  int LOCKOUT  = 4,
  localparam int IDX_W    = $clog2(NUM_CAND),
  localparam int TOT_W    = COUNT_W + IDX_W + 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        mode,
  input  logic                        clear,
  input  logic [NUM_CAND-1:0]         cand_press,
  output logic [NUM_CAND*COUNT_W-1:0] counts,
  output logic [TOT_W-1:0]            total,
  output logic                        vote_accept,
  output logic                        vote_reject,
  output logic [IDX_W-1:0]            winner_idx,
  output logic                        winner_valid,
  output logic                        tie,
  output logic                        busy
);

  localparam logic [31:0]        CNT_MAX_W = sat_max(COUNT_W);
  localparam logic [COUNT_W-1:0] CNT_MAX   = CNT_MAX_W[COUNT_W-1:0];
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CAND - 1);

  logic [COUNT_W-1:0] count_q [NUM_CAND];
  logic [TOT_W-1:0]   total_q;
  logic [NUM_CAND-1:0] sat_s;
  logic               acc_s;
  logic [IDX_W-1:0]   acc_idx_s;

  scan_state_e        scan_q, scan_d;
  logic               mode_q;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic [COUNT_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]   best_q, best_d;
  logic               tie_q, tie_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [COUNT_W-1:0] cur_s;

  vote_press_filter #(
    .NUM_CAND (NUM_CAND),
    .LOCKOUT  (LOCKOUT),
    .IDX_W    (IDX_W)
  ) u_filter (
    .clock_i  (clock),
    .reset_ni (reset_n),
    .mode_i   (mode),
    .clear_i  (clear),
    .press_i  (cand_press),
    .sat_i    (sat_s),
    .valid_o  (acc_s),
    .reject_o (vote_reject),
    .idx_o    (acc_idx_s)
  );

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
    assign counts[g*COUNT_W +: COUNT_W] = count_q[g];
    assign sat_s[g] = (count_q[g] == CNT_MAX);
  end

  // Tally array and running total; clear overrides a pending increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        count_q[i] <= '0;
      end
      total_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        count_q[i] <= '0;
      end
      total_q <= '0;
    end else if (acc_s) begin
      count_q[acc_idx_s] <= count_q[acc_idx_s] + COUNT_W'(1);
      total_q            <= total_q + TOT_W'(1);
    end
  end

  assign cur_s = count_q[scan_idx_q];

  // Leader scan; strict greater-than keeps the lowest index among equals.
  always_comb begin
    scan_d     = scan_q;
    scan_idx_d = scan_idx_q;
    max_d      = max_q;
    best_d     = best_q;
    tie_d      = tie_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    if (clear || (!mode && mode_q)) begin
      scan_d  = SCAN_IDLE;
      valid_d = 1'b0;
      tie_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (mode && !mode_q) begin
      scan_d     = SCAN_RUN;
      scan_idx_d = '0;
      valid_d    = 1'b0;
      tie_d      = 1'b0;
      busy_d     = 1'b1;
    end else begin
      case (scan_q)
        SCAN_RUN: begin
          if (scan_idx_q == '0) begin
            max_d  = cur_s;
            best_d = '0;
            tie_d  = 1'b0;
          end else if (cur_s > max_q) begin
            max_d  = cur_s;
            best_d = scan_idx_q;
            tie_d  = 1'b0;
          end else if (cur_s == max_q) begin
            tie_d = 1'b1;
          end else begin
            tie_d = tie_q;
          end
          if (scan_idx_q == LAST_IDX) begin
            scan_d  = SCAN_DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
          end
        end
        SCAN_IDLE, SCAN_DONE: begin
          scan_d = scan_q;
        end
        default: begin
          scan_d  = SCAN_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Scan state and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_q     <= SCAN_IDLE;
      mode_q     <= 1'b0;
      scan_idx_q <= '0;
      max_q      <= '0;
      best_q     <= '0;
      tie_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scan_q     <= scan_d;
      mode_q     <= mode;
      scan_idx_q <= scan_idx_d;
      max_q      <= max_d;
      best_q     <= best_d;
      tie_q      <= tie_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign total        = total_q;
  assign vote_accept  = acc_s;
  assign winner_idx   = best_q;
  assign winner_valid = valid_q;
  assign tie          = tie_q;
  assign busy         = busy_q;

endmodule
